// File: rtl/dsp38_pkg.sv
// Shared definitions for the DSP38 multiply-accumulate sequencer: FSM states,
// feedback encodings and the capture latency of the attached DSP38.
package dsp38_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  localparam logic [2:0] FB_ACCUM = 3'b000;
  localparam logic [2:0] FB_CLEAR = 3'b001;

  // Edges from the one that drives the last pair to the one where DSP_Z is valid:
  // optional input register, accumulator register, optional output register.
  function automatic int dsp_latency(input int in_reg, input int out_reg);
    return 1 + in_reg + 1 + out_reg;
  endfunction

endpackage

// File: rtl/dsp38_mac_sequencer.sv
// Feeds dot-product jobs into one DSP38 in multiply-accumulate mode and
// returns the final accumulator value on a valid/ready result port.
module dsp38_mac_sequencer
  import dsp38_pkg::*;
#(
  parameter int DSP_IN_REG  = 1,
  parameter int DSP_OUT_REG = 1,
  parameter int LEN_W       = 6
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [LEN_W-1:0] CFG_LEN,
  input  logic [5:0]       CFG_SHIFT_RIGHT,
  input  logic             CFG_ROUND,
  input  logic             CFG_SATURATE,
  input  logic             CFG_UNSIGNED_A,
  input  logic             CFG_UNSIGNED_B,
  input  logic             S_VALID,
  output logic             S_READY,
  input  logic [19:0]      S_A,
  input  logic [17:0]      S_B,
  input  logic             S_SUB,
  output logic             M_VALID,
  input  logic             M_READY,
  output logic [37:0]      M_DATA,
  output logic [19:0]      DSP_A,
  output logic [17:0]      DSP_B,
  output logic [2:0]       DSP_FEEDBACK,
  output logic             DSP_LOAD_ACC,
  output logic             DSP_SUBTRACT,
  output logic [5:0]       DSP_ACC_FIR,
  output logic [5:0]       DSP_SHIFT_RIGHT,
  output logic             DSP_ROUND,
  output logic             DSP_SATURATE,
  output logic             DSP_UNSIGNED_A,
  output logic             DSP_UNSIGNED_B,
  input  logic [37:0]      DSP_Z
);

  localparam int LAT   = dsp_latency(DSP_IN_REG, DSP_OUT_REG);
  localparam int LAT_W = $clog2(LAT + 1);

  state_e             state_q, state_d;
  logic [LEN_W:0]     cnt_q, cnt_d;
  logic [LEN_W:0]     len_q, len_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic               m_valid_q, m_valid_d;
  logic [37:0]        m_data_q, m_data_d;
  logic [19:0]        a_q, a_d;
  logic [17:0]        b_q, b_d;
  logic               sub_q, sub_d;
  logic               load_q, load_d;
  logic [2:0]         fb_q, fb_d;
  logic [5:0]         shift_q, shift_d;
  logic               round_q, round_d;
  logic               sat_q, sat_d;
  logic               ua_q, ua_d;
  logic               ub_q, ub_d;

  logic               rx_state;
  logic               accept;
  logic [LEN_W:0]     len_in;
  logic [LEN_W:0]     cnt_inc;

  // Ready is gated by RESET itself so it is low for the whole reset pulse and
  // high from the very first cycle after release.
  assign rx_state = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
  assign S_READY  = rx_state && !RESET;
  assign accept   = S_VALID && S_READY;

  // A zero length field encodes the full 2^LEN_W pairs.
  assign len_in  = {(CFG_LEN == '0), CFG_LEN};
  assign cnt_inc = cnt_q + (LEN_W + 1)'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    lat_d     = lat_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    a_d       = a_q;
    b_d       = b_q;
    sub_d     = sub_q;
    load_d    = 1'b0;
    fb_d      = FB_ACCUM;
    shift_d   = shift_q;
    round_d   = round_q;
    sat_d     = sat_q;
    ua_d      = ua_q;
    ub_d      = ub_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          len_d   = len_in;
          shift_d = CFG_SHIFT_RIGHT;
          round_d = CFG_ROUND;
          sat_d   = CFG_SATURATE;
          ua_d    = CFG_UNSIGNED_A;
          ub_d    = CFG_UNSIGNED_B;
          cnt_d   = (LEN_W + 1)'(1);
          a_d     = S_A;
          b_d     = S_B;
          sub_d   = S_SUB;
          load_d  = 1'b1;
          fb_d    = FB_CLEAR;
          lat_d   = LAT_W'(1);
          state_d = (len_in == (LEN_W + 1)'(1)) ? ST_DRAIN : ST_ACCUM;
        end
      end

      ST_ACCUM: begin
        if (accept) begin
          a_d    = S_A;
          b_d    = S_B;
          sub_d  = S_SUB;
          load_d = 1'b1;
          cnt_d  = cnt_inc;
          if (cnt_inc == len_q) begin
            lat_d   = LAT_W'(1);
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        // lat_q counts edges since the one that drove the last pair.
        if (lat_q == LAT_W'(LAT)) begin
          m_data_d  = DSP_Z;
          m_valid_d = 1'b1;
          state_d   = ST_HOLD;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end

      ST_HOLD: begin
        if (M_READY) begin
          m_valid_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      lat_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      load_q    <= 1'b0;
      fb_q      <= FB_ACCUM;
      shift_q   <= '0;
      round_q   <= 1'b0;
      sat_q     <= 1'b0;
      ua_q      <= 1'b1;
      ub_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      lat_q     <= lat_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sub_q     <= sub_d;
      load_q    <= load_d;
      fb_q      <= fb_d;
      shift_q   <= shift_d;
      round_q   <= round_d;
      sat_q     <= sat_d;
      ua_q      <= ua_d;
      ub_q      <= ub_d;
    end
  end

  assign M_VALID         = m_valid_q;
  assign M_DATA          = m_data_q;
  assign DSP_A           = a_q;
  assign DSP_B           = b_q;
  assign DSP_SUBTRACT    = sub_q;
  assign DSP_LOAD_ACC    = load_q;
  assign DSP_FEEDBACK    = fb_q;
  assign DSP_ACC_FIR     = 6'd0;
  assign DSP_SHIFT_RIGHT = shift_q;
  assign DSP_ROUND       = round_q;
  assign DSP_SATURATE    = sat_q;
  assign DSP_UNSIGNED_A  = ua_q;
  assign DSP_UNSIGNED_B  = ub_q;

endmodule

// File: tb/tb_dsp38_mac_sequencer.sv
// Bench for dsp38_mac_sequencer with a behavioural DSP38 (input reg, accumulator,
// output reg) attached; results are checked against job-level dot products.
module tb_dsp38_mac_sequencer;

  localparam int LEN_W = 6;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic [LEN_W-1:0] CFG_LEN = '0;
  logic [5:0]       CFG_SHIFT_RIGHT = '0;
  logic             CFG_ROUND = 1'b0, CFG_SATURATE = 1'b0;
  logic             CFG_UNSIGNED_A = 1'b1, CFG_UNSIGNED_B = 1'b1;
  logic             S_VALID = 1'b0;
  logic             S_READY;
  logic [19:0]      S_A = '0;
  logic [17:0]      S_B = '0;
  logic             S_SUB = 1'b0;
  logic             M_VALID;
  logic             M_READY = 1'b1;
  logic [37:0]      M_DATA;
  logic [19:0]      DSP_A;
  logic [17:0]      DSP_B;
  logic [2:0]       DSP_FEEDBACK;
  logic             DSP_LOAD_ACC, DSP_SUBTRACT;
  logic [5:0]       DSP_ACC_FIR, DSP_SHIFT_RIGHT;
  logic             DSP_ROUND, DSP_SATURATE, DSP_UNSIGNED_A, DSP_UNSIGNED_B;
  logic [37:0]      DSP_Z;

  always #5 CLK = ~CLK;

  dsp38_mac_sequencer #(.DSP_IN_REG(1), .DSP_OUT_REG(1), .LEN_W(LEN_W)) dut (
    .CLK(CLK), .RESET(RESET), .CFG_LEN(CFG_LEN), .CFG_SHIFT_RIGHT(CFG_SHIFT_RIGHT),
    .CFG_ROUND(CFG_ROUND), .CFG_SATURATE(CFG_SATURATE),
    .CFG_UNSIGNED_A(CFG_UNSIGNED_A), .CFG_UNSIGNED_B(CFG_UNSIGNED_B),
    .S_VALID(S_VALID), .S_READY(S_READY), .S_A(S_A), .S_B(S_B), .S_SUB(S_SUB),
    .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA),
    .DSP_A(DSP_A), .DSP_B(DSP_B), .DSP_FEEDBACK(DSP_FEEDBACK), .DSP_LOAD_ACC(DSP_LOAD_ACC),
    .DSP_SUBTRACT(DSP_SUBTRACT), .DSP_ACC_FIR(DSP_ACC_FIR), .DSP_SHIFT_RIGHT(DSP_SHIFT_RIGHT),
    .DSP_ROUND(DSP_ROUND), .DSP_SATURATE(DSP_SATURATE),
    .DSP_UNSIGNED_A(DSP_UNSIGNED_A), .DSP_UNSIGNED_B(DSP_UNSIGNED_B), .DSP_Z(DSP_Z)
  );

  int          tests = 0;
  int          fails = 0;
  longint      cyc = 0;
  int          rdy_hold = 0;
  bit          rdy_rand = 1'b0;
  int          ja [64];
  int          jb [64];
  bit          js [64];
  logic [37:0] exp_data [$];
  longint      exp_cyc [$];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Sign- or zero-extend the low w bits of v.
  function automatic longint sx(input longint v, input int w, input bit u);
    longint m;
    m = v & ((longint'(1) << w) - 1);
    if (!u && m[w-1]) m = m - (longint'(1) << w);
    return m;
  endfunction

  // DSP38 output post-processing: arithmetic shift, optional round-half-up, optional clamp.
  function automatic logic [37:0] post(input longint v, input int sh, input bit rnd, input bit sat);
    longint r;
    longint maxv;
    maxv = (longint'(1) << 37) - 1;
    r = v;
    if (sh > 0) begin
      if (rnd) r = r + (longint'(1) << (sh - 1));
      r = r >>> sh;
    end
    if (sat) begin
      if (r > maxv) r = maxv;
      else if (r < -maxv - 1) r = -maxv - 1;
    end
    return r[37:0];
  endfunction

  // Behavioural DSP38, INPUT_REG_EN and OUTPUT_REG_EN both TRUE.
  logic [19:0] ia;
  logic [17:0] ib;
  logic        isub, iload, iua, iub;
  logic [2:0]  ifb;
  longint      acc;
  logic [37:0] z_q;
  assign DSP_Z = z_q;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ia <= '0; ib <= '0; isub <= 1'b0; iload <= 1'b0; iua <= 1'b1; iub <= 1'b1;
      ifb <= 3'b000; acc <= 0; z_q <= '0;
    end else begin
      ia <= DSP_A; ib <= DSP_B; isub <= DSP_SUBTRACT; iload <= DSP_LOAD_ACC;
      ifb <= DSP_FEEDBACK; iua <= DSP_UNSIGNED_A; iub <= DSP_UNSIGNED_B;
      if (iload)
        acc <= ((ifb == 3'b001) ? 64'sd0 : acc) +
               (isub ? -(sx(longint'(ia), 20, iua) * sx(longint'(ib), 18, iub))
                     :  (sx(longint'(ia), 20, iua) * sx(longint'(ib), 18, iub)));
      z_q <= post(acc, int'(DSP_SHIFT_RIGHT), DSP_ROUND, DSP_SATURATE);
    end
  end

  // Job-level reference: signed/unsigned dot product of the pair table, then post-processing.
  function automatic logic [37:0] ref_result(input int len, input int sh, input bit rnd,
                                             input bit sat, input bit ua, input bit ub);
    longint sum;
    longint p;
    sum = 0;
    for (int i = 0; i < len; i++) begin
      p = sx(longint'(ja[i]), 20, ua) * sx(longint'(jb[i]), 18, ub);
      sum = js[i] ? sum - p : sum + p;
    end
    return post(sum, sh, rnd, sat);
  endfunction

  // Sends nsend pairs from the tables; enters and leaves at a falling edge.
  task automatic run_job(input int len_cfg, input int nsend, input int sh, input bit rnd,
                         input bit sat, input bit ua, input bit ub,
                         input int gap_at, input int gap_len, input bit rgaps);
    int     len;
    int     ta, tb, r;
    bit     ok;
    int     tmo;
    longint edge_c;
    len = (len_cfg == 0) ? 64 : len_cfg;
    edge_c = 0;
    CFG_LEN = len_cfg[LEN_W-1:0];
    CFG_SHIFT_RIGHT = sh[5:0];
    CFG_ROUND = rnd; CFG_SATURATE = sat; CFG_UNSIGNED_A = ua; CFG_UNSIGNED_B = ub;
    for (int i = 0; i < nsend; i++) begin
      if (i > 0 && i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          S_VALID = 1'b0;
          @(posedge CLK); @(negedge CLK);
          check("gap_load_acc", longint'(DSP_LOAD_ACC), 0);
        end
      end else if (i > 0 && rgaps && $urandom_range(0, 3) == 0) begin
        S_VALID = 1'b0;
        @(posedge CLK); @(negedge CLK);
        check("gap_load_acc", longint'(DSP_LOAD_ACC), 0);
      end
      ta = ja[i]; tb = jb[i];
      S_VALID = 1'b1; S_A = ta[19:0]; S_B = tb[17:0]; S_SUB = js[i];
      tmo = 0;
      do begin
        ok = S_READY;
        @(posedge CLK); @(negedge CLK);
        tmo++;
      end while (!ok && tmo < 400);
      if (!ok) begin
        check("accept_timeout", 0, 1);
        S_VALID = 1'b0;
        return;
      end
      edge_c = cyc;
      check("dsp_a", longint'(DSP_A), longint'(ta[19:0]));
      check("dsp_b", longint'(DSP_B), longint'(tb[17:0]));
      check("dsp_sub_load", longint'({DSP_SUBTRACT, DSP_LOAD_ACC}), longint'({js[i], 1'b1}));
      check("dsp_feedback", longint'(DSP_FEEDBACK), (i == 0) ? 1 : 0);
      check("dsp_acc_fir", longint'(DSP_ACC_FIR), 0);
      if (i == 0 || i == nsend - 1)
        check("dsp_cfg", longint'({DSP_SHIFT_RIGHT, DSP_ROUND, DSP_SATURATE, DSP_UNSIGNED_A, DSP_UNSIGNED_B}),
              longint'({sh[5:0], rnd, sat, ua, ub}));
      if (i == 0) begin
        // Config changes after job start must have no effect.
        r = int'($urandom);
        CFG_LEN = r[LEN_W-1:0]; CFG_SHIFT_RIGHT = r[13:8];
        CFG_ROUND = r[16]; CFG_SATURATE = r[17]; CFG_UNSIGNED_A = r[18]; CFG_UNSIGNED_B = r[19];
      end
    end
    S_VALID = 1'b0;
    if (nsend == len) begin
      exp_data.push_back(ref_result(len, sh, rnd, sat, ua, ub));
      exp_cyc.push_back(edge_c + 4);
    end
  endtask

  task automatic drain_wait();
    int tmo;
    tmo = 0;
    while ((exp_data.size() != 0 || M_VALID) && tmo < 300) begin
      @(negedge CLK);
      tmo++;
    end
    if (tmo >= 300) check("drain_timeout", 0, 1);
  endtask

  // Result handshake driver.
  initial begin
    forever begin
      @(negedge CLK);
      if (rdy_hold > 0) begin
        M_READY = 1'b0;
        rdy_hold--;
      end else begin
        M_READY = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Scoreboard monitor: pops an expectation each time M_VALID rises.
  initial begin
    bit          was_v;
    logic [37:0] held;
    logic [37:0] d;
    longint      c;
    was_v = 1'b0;
    held = '0;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        was_v = 1'b0;
      end else begin
        if (M_VALID && !was_v) begin
          if (exp_data.size() == 0) begin
            check("unexpected_result", longint'(M_DATA), -1);
          end else begin
            d = exp_data.pop_front();
            c = exp_cyc.pop_front();
            $display("[TB] result 0x%0h expected 0x%0h at cycle %0d", M_DATA, d, cyc);
            check("m_data", longint'(M_DATA), longint'(d));
            check("m_valid_latency", cyc, c);
          end
          held = M_DATA;
        end else if (M_VALID) begin
          check("m_data_hold", longint'(M_DATA), longint'(held));
          check("s_ready_in_hold", longint'(S_READY), 0);
        end
        was_v = M_VALID;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    repeat (3) @(negedge CLK);
    check("rst_s_ready", longint'(S_READY), 0);
    check("rst_m_valid", longint'(M_VALID), 0);
    check("rst_m_data", longint'(M_DATA), 0);
    check("rst_dsp_ctl", longint'({DSP_LOAD_ACC, DSP_FEEDBACK, DSP_SUBTRACT}), 0);
    check("rst_dsp_unsigned", longint'({DSP_UNSIGNED_A, DSP_UNSIGNED_B}), 3);
    RESET = 1'b0;
    #1;
    check("s_ready_after_reset", longint'(S_READY), 1);

    // Single pair, unsigned: 3*5
    ja[0] = 3; jb[0] = 5; js[0] = 0;
    run_job(1, 1, 0, 0, 0, 1, 1, -1, 0, 0);

    // Four signed pairs
    ja[0] = -2; ja[1] = 4; ja[2] = 7;  ja[3] = -1;
    jb[0] = 3;  jb[1] = 3; jb[2] = -2; jb[3] = 10;
    for (int i = 0; i < 4; i++) js[i] = 0;
    run_job(4, 4, 0, 0, 0, 0, 0, -1, 0, 0);

    // Subtract with a three-cycle gap: 10*10 - 2*3
    ja[0] = 10; jb[0] = 10; js[0] = 0;
    ja[1] = 2;  jb[1] = 3;  js[1] = 1;
    run_job(2, 2, 0, 0, 0, 1, 1, 1, 3, 0);

    // Back-to-back jobs with the first result stalled
    drain_wait();
    rdy_hold = 11;
    ja[0] = 3; jb[0] = 5; js[0] = 0;
    run_job(1, 1, 0, 0, 0, 1, 1, -1, 0, 0);
    ja[0] = 7; jb[0] = 1; js[0] = 0;
    run_job(1, 1, 0, 0, 0, 1, 1, -1, 0, 0);

    // Shift by 2 with and without rounding
    ja[0] = 3; jb[0] = 5; js[0] = 0;
    run_job(1, 1, 2, 1, 0, 1, 1, -1, 0, 0);
    run_job(1, 1, 2, 0, 0, 1, 1, -1, 0, 0);

    // Reset after 2 of 4 pairs, then a fresh job 6*7
    drain_wait();
    for (int i = 0; i < 4; i++) begin ja[i] = i + 1; jb[i] = 9; js[i] = 0; end
    run_job(4, 2, 0, 0, 0, 1, 1, -1, 0, 0);
    RESET = 1'b1;
    #1;
    check("midjob_rst_m_valid", longint'(M_VALID), 0);
    check("midjob_rst_s_ready", longint'(S_READY), 0);
    check("midjob_rst_load_acc", longint'(DSP_LOAD_ACC), 0);
    @(negedge CLK); @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("midjob_rst_idle", longint'(S_READY), 1);
    ja[0] = 6; jb[0] = 7; js[0] = 0;
    run_job(1, 1, 0, 0, 0, 1, 1, -1, 0, 0);

    // Randomized jobs with gaps and result backpressure
    rdy_rand = 1'b1;
    for (int j = 0; j < 25; j++) begin
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        ja[i] = int'($urandom); jb[i] = int'($urandom); js[i] = 1'($urandom_range(0, 1));
      end
      run_job(len, len, $urandom_range(0, 12), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, 0, 1);
    end

    // Full-length job encoded as CFG_LEN=0
    for (int i = 0; i < 64; i++) begin
      ja[i] = int'($urandom_range(0, 4095)) - 2048;
      jb[i] = int'($urandom_range(0, 4095)) - 2048;
      js[i] = 1'($urandom_range(0, 1));
    end
    run_job(0, 64, 1, 1, 0, 0, 0, -1, 0, 1);

    drain_wait();
    check("queue_empty", longint'(exp_data.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
